// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble per-digit adjust: a digit of 5 or more gets +3 so the next
// left shift carries correctly into the following decimal digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one adjust-and-shift per clock, W clocks
// per conversion, result registers held stable between completions.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic [4*D-1:0] bcd,
  output logic           ovf,
  output logic           valid,
  output logic           busy
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam int BW    = 4 * D;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     sh;
  logic [W-1:0]     sh_nxt;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    acc_adj;
  logic [BW-1:0]    acc_nxt;
  logic             ovf_acc;
  logic             ovf_nxt;
  logic             accept;
  logic             last;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit means the running prefix reached 10^D.
  assign acc_nxt = {acc_adj[BW-2:0], sh[W-1]};
  assign ovf_nxt = ovf_acc | acc_adj[BW-1];
  assign sh_nxt  = sh << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == SHIFT);
    accept = (state == IDLE) && start;
    last   = (state == SHIFT) && (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      sh      <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= last;
      if (accept) begin
        sh      <= bin;
        acc     <= '0;
        ovf_acc <= 1'b0;
        cnt     <= CNT_INIT;
      end else if (state == SHIFT) begin
        sh      <= sh_nxt;
        acc     <= acc_nxt;
        ovf_acc <= ovf_nxt;
        if (!last) cnt <= cnt - 1'b1;
      end
      if (last) begin
        bcd <= acc_nxt;
        ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: arithmetic reference model for the default build plus
// directed conversions on a default (W=8) and a wide (W=10) instance.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;
  logic        ovf8, valid8, busy8;
  logic        start10;
  logic [9:0]  bin10;
  logic [11:0] bcd10;
  logic        ovf10, valid10, busy10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(8), .D(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .bcd(bcd8), .ovf(ovf8), .valid(valid8), .busy(busy8)
  );

  bin2bcd_seq #(.W(10), .D(3)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .bin(bin10),
    .bcd(bcd10), .ovf(ovf10), .valid(valid10), .busy(busy10)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r[11:0];
  endfunction

  // Reference model of the W=8 instance: remaining-shift count and result regs.
  int          m_cnt;
  logic [11:0] m_bcd, m_pend_bcd;
  logic        m_ovf, m_pend_ovf, m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_bcd   <= '0;
      m_ovf   <= 1'b0;
      m_valid <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt   <= m_cnt - 1;
      m_valid <= (m_cnt == 1);
      if (m_cnt == 1) begin
        m_bcd <= m_pend_bcd;
        m_ovf <= m_pend_ovf;
      end
    end else begin
      m_valid <= 1'b0;
      if (start8) begin
        m_pend_bcd <= to_bcd(int'(bin8));
        m_pend_ovf <= (int'(bin8) >= 1000);
        m_cnt      <= 8;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_valid", valid8, m_valid);
      check("model_busy", busy8, m_cnt > 0);
      check("model_bcd", bcd8, m_bcd);
      check("model_ovf", ovf8, m_ovf);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic conv8(input logic [7:0] v, input logic [11:0] exp_bcd);
    int lat;
    lat = -1;
    start8 = 1'b1;
    bin8   = v;
    step();
    start8 = 1'b0;
    bin8   = ~v;
    check("busy_after_capture", busy8, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (valid8) begin
        lat = k;
        break;
      end
    end
    check("latency8", lat, 8);
    check("bcd8", bcd8, exp_bcd);
    check("ovf8", ovf8, 1'b0);
    step();
    check("valid8_one_cycle", valid8, 1'b0);
  endtask

  task automatic conv10(input logic [9:0] v, input logic [11:0] exp_bcd, input logic exp_ovf);
    int lat;
    lat = -1;
    start10 = 1'b1;
    bin10   = v;
    step();
    start10 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (valid10) begin
        lat = k;
        break;
      end
    end
    check("latency10", lat, 10);
    check("bcd10", bcd10, exp_bcd);
    check("ovf10", ovf10, exp_ovf);
    step();
  endtask

  initial begin
    int nv;
    int times[3];
    logic [11:0] seen;

    start8 = 1'b0; bin8 = '0; start10 = 1'b0; bin10 = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_bcd8", bcd8, 12'h000);
    check("rst_valid8", valid8, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_ovf10", ovf10, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    check("idle_busy8", busy8, 1'b0);

    conv8(8'd137, 12'h137);
    conv8(8'd0,   12'h000);
    conv8(8'd255, 12'h255);

    // Second start arrives while busy and must be dropped.
    nv = 0; seen = '0;
    start8 = 1'b1; bin8 = 8'd99;
    step();
    start8 = 1'b0;
    step(); step();
    start8 = 1'b1; bin8 = 8'd42;
    step();
    start8 = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (valid8) begin
        nv++;
        seen = bcd8;
      end
      step();
    end
    check("busy_start_pulses", nv, 1);
    check("busy_start_bcd", seen, 12'h099);

    // Start held high: one result every W+1 cycles.
    nv = 0;
    start8 = 1'b1; bin8 = 8'd9;
    step();
    for (int k = 1; k <= 40; k++) begin
      step();
      if (valid8) begin
        times[nv] = k;
        nv++;
        check("b2b_bcd", bcd8, 12'h009);
        if (nv == 3) begin
          start8 = 1'b0;
          break;
        end
      end
    end
    check("b2b_count", nv, 3);
    if (nv == 3) begin
      check("b2b_period_a", times[1] - times[0], 9);
      check("b2b_period_b", times[2] - times[1], 9);
    end
    for (int k = 0; k < 12; k++) step();

    // Asynchronous reset in the middle of a conversion.
    start8 = 1'b1; bin8 = 8'd200;
    step();
    start8 = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("midrst_bcd", bcd8, 12'h000);
    check("midrst_busy", busy8, 1'b0);
    check("midrst_valid", valid8, 1'b0);
    step();
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (valid8) nv++;
    end
    check("midrst_no_valid", nv, 0);
    check("midrst_bcd_hold", bcd8, 12'h000);

    conv10(10'd1000, 12'h000, 1'b1);
    conv10(10'd1023, 12'h023, 1'b1);
    conv10(10'd999,  12'h999, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
